// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite register bank: NUM_REGS 32-bit read/write registers with independent write and read FSMs.
// Register 0 is also driven out live as a control word.
//
// state  | meaning
// W_IDLE | ready for AW and W, alone or together
// W_ADDR | write address held, waiting for W
// W_DATA | write data/strobe held, waiting for AW
// W_RESP | write committed, b_valid until b_ready
// R_IDLE | ready for AR
// R_RESP | read data held, r_valid until r_ready
module axi_lite_slave_regs #(
   parameter int          NUM_REGS  = 8,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        a_clk,
   input  logic        a_reset,
   input  logic [31:0] aw_addr,
   input  logic        aw_valid,
   output logic        aw_ready,
   input  logic [31:0] w_data,
   input  logic [3:0]  w_strb,
   input  logic        w_valid,
   output logic        w_ready,
   output logic [1:0]  b_resp,
   output logic        b_valid,
   input  logic        b_ready,
   input  logic [31:0] ar_addr,
   input  logic        ar_valid,
   output logic        ar_ready,
   output logic [31:0] r_data,
   output logic [1:0]  r_resp,
   output logic        r_valid,
   input  logic        r_ready,
   output logic [31:0] reg0_out
);

   localparam int          IDX_W  = $clog2(NUM_REGS);
   localparam logic [31:0] SPAN   = 32'(4 * NUM_REGS);
   localparam logic [1:0]  OKAY   = 2'b00;
   localparam logic [1:0]  SLVERR = 2'b10;

   typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_t;
   typedef enum logic       {R_IDLE, R_RESP} r_state_t;

   w_state_t w_state, w_next;
   r_state_t r_state, r_next;

   logic [31:0] regs [NUM_REGS];
   logic [31:0] aw_addr_q, w_data_q;
   logic [3:0]  w_strb_q;

   logic             wr_commit;
   logic [31:0]      wr_addr_sel, wr_data_sel;
   logic [3:0]       wr_strb_sel;
   logic [32:0]      wr_diff, rd_diff;
   logic             wr_hit, rd_hit, ar_hs;
   logic [IDX_W-1:0] wr_idx, rd_idx;

   // 33-bit subtraction: bit 32 set means the address lies below BASE_ADDR
   always_comb begin
      wr_diff = {1'b0, wr_addr_sel} - {1'b0, BASE_ADDR};
      rd_diff = {1'b0, ar_addr} - {1'b0, BASE_ADDR};
      wr_hit  = !wr_diff[32] && (wr_diff[31:0] < SPAN);
      rd_hit  = !rd_diff[32] && (rd_diff[31:0] < SPAN);
      wr_idx  = wr_diff[IDX_W+1:2];
      rd_idx  = rd_diff[IDX_W+1:2];
   end

   always_ff @(posedge a_clk) begin
      if (a_reset) begin
         w_state <= W_IDLE;
         r_state <= R_IDLE;
      end else begin
         w_state <= w_next;
         r_state <= r_next;
      end
   end

   always_comb begin
      w_next      = w_state;
      aw_ready    = 1'b0;
      w_ready     = 1'b0;
      b_valid     = 1'b0;
      wr_commit   = 1'b0;
      wr_addr_sel = aw_addr;
      wr_data_sel = w_data;
      wr_strb_sel = w_strb;
      case (w_state)
         W_IDLE: begin
            aw_ready = 1'b1;
            w_ready  = 1'b1;
            if (aw_valid && w_valid) begin
               wr_commit = 1'b1;
               w_next    = W_RESP;
            end else if (aw_valid) begin
               w_next = W_ADDR;
            end else if (w_valid) begin
               w_next = W_DATA;
            end
         end
         W_ADDR: begin
            w_ready     = 1'b1;
            wr_addr_sel = aw_addr_q;
            if (w_valid) begin
               wr_commit = 1'b1;
               w_next    = W_RESP;
            end
         end
         W_DATA: begin
            aw_ready    = 1'b1;
            wr_data_sel = w_data_q;
            wr_strb_sel = w_strb_q;
            if (aw_valid) begin
               wr_commit = 1'b1;
               w_next    = W_RESP;
            end
         end
         W_RESP: begin
            b_valid = 1'b1;
            if (b_ready) w_next = W_IDLE;
         end
         default: w_next = W_IDLE;
      endcase
   end

   always_comb begin
      r_next   = r_state;
      ar_ready = (r_state == R_IDLE);
      r_valid  = (r_state == R_RESP);
      ar_hs    = ar_ready && ar_valid;
      if (ar_hs) r_next = R_RESP;
      else if (r_valid && r_ready) r_next = R_IDLE;
   end

   always_ff @(posedge a_clk) begin
      if (a_reset) begin
         aw_addr_q <= '0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         b_resp    <= OKAY;
         r_data    <= '0;
         r_resp    <= OKAY;
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else begin
         if (w_state == W_IDLE && aw_valid && !w_valid) aw_addr_q <= aw_addr;
         if (w_state == W_IDLE && w_valid && !aw_valid) begin
            w_data_q <= w_data;
            w_strb_q <= w_strb;
         end
         if (wr_commit) begin
            b_resp <= wr_hit ? OKAY : SLVERR;
            if (wr_hit) begin
               for (int b = 0; b < 4; b++)
                  if (wr_strb_sel[b]) regs[wr_idx][8*b +: 8] <= wr_data_sel[8*b +: 8];
            end
         end
         // regs read here is the pre-commit value when a write lands on the same edge
         if (ar_hs) begin
            r_data <= rd_hit ? regs[rd_idx] : 32'h0;
            r_resp <= rd_hit ? OKAY : SLVERR;
         end
      end
   end

   assign reg0_out = regs[0];

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Directed bench for axi_lite_slave_regs: a vector table of single writes/reads plus
// hand-written sequences for W-before-AW, backpressure with same-register read/write, and reset.
module tb_axi_lite_slave_regs;

   logic        a_clk = 1'b0;
   logic        a_reset;
   logic [31:0] aw_addr, w_data, ar_addr;
   logic        aw_valid, w_valid, b_ready, ar_valid, r_ready;
   logic [3:0]  w_strb;
   logic        aw_ready, w_ready, b_valid, ar_ready, r_valid;
   logic [1:0]  b_resp, r_resp;
   logic [31:0] r_data, reg0_out;

   int checks = 0;
   int errors = 0;

   axi_lite_slave_regs #(.NUM_REGS(8), .BASE_ADDR(32'h0)) dut (
      .a_clk(a_clk), .a_reset(a_reset),
      .aw_addr(aw_addr), .aw_valid(aw_valid), .aw_ready(aw_ready),
      .w_data(w_data), .w_strb(w_strb), .w_valid(w_valid), .w_ready(w_ready),
      .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
      .ar_addr(ar_addr), .ar_valid(ar_valid), .ar_ready(ar_ready),
      .r_data(r_data), .r_resp(r_resp), .r_valid(r_valid), .r_ready(r_ready),
      .reg0_out(reg0_out)
   );

   always #5 a_clk = ~a_clk;

   typedef struct {
      bit          is_wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [31:0] exp_data;
      logic [1:0]  exp_resp;
   } vec_t;

   vec_t vecs [16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge a_clk);
      #1;
   endtask

   task automatic wait_true(input string name, input logic cond_a, input logic cond_b);
      chk(name, {31'b0, cond_a && cond_b}, 32'h1);
   endtask

   // AW and W presented together; returns the B response
   task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp);
      int n = 0;
      aw_addr = a; w_data = d; w_strb = s; aw_valid = 1'b1; w_valid = 1'b1;
      while (!(aw_ready && w_ready) && n < 20) begin tick(); n++; end
      wait_true("write_accept", aw_ready, w_ready);
      tick();
      aw_valid = 1'b0; w_valid = 1'b0;
      chk("b_valid_latency", {31'b0, b_valid}, 32'h1);
      resp = b_resp;
      b_ready = 1'b1;
      tick();
      b_ready = 1'b0;
   endtask

   task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
      int n = 0;
      ar_addr = a; ar_valid = 1'b1;
      while (!ar_ready && n < 20) begin tick(); n++; end
      wait_true("read_accept", ar_ready, 1'b1);
      tick();
      ar_valid = 1'b0;
      chk("r_valid_latency", {31'b0, r_valid}, 32'h1);
      d = r_data;
      resp = r_resp;
      r_ready = 1'b1;
      tick();
      r_ready = 1'b0;
   endtask

   logic [31:0] rd;
   logic [1:0]  rs;

   initial begin
      a_reset = 1'b1;
      aw_addr = '0; aw_valid = 0; w_data = '0; w_strb = '0; w_valid = 0; b_ready = 0;
      ar_addr = '0; ar_valid = 0; r_ready = 0;

      vecs[0]  = '{1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 4'hF, 32'h0,          2'b00};
      vecs[1]  = '{1'b0, 32'h0000_0004, 32'h0,         4'h0, 32'hDEAD_BEEF,  2'b00};
      vecs[2]  = '{1'b1, 32'h0000_0004, 32'hFFFF_FFFF, 4'hF, 32'h0,          2'b00};
      vecs[3]  = '{1'b1, 32'h0000_0004, 32'h0000_00AA, 4'h1, 32'h0,          2'b00};
      vecs[4]  = '{1'b0, 32'h0000_0004, 32'h0,         4'h0, 32'hFFFF_FFAA,  2'b00};
      vecs[5]  = '{1'b1, 32'h0000_0006, 32'h1234_0000, 4'hC, 32'h0,          2'b00};
      vecs[6]  = '{1'b0, 32'h0000_0005, 32'h0,         4'h0, 32'h1234_FFAA,  2'b00};
      vecs[7]  = '{1'b1, 32'h0000_001C, 32'hCAFE_F00D, 4'hF, 32'h0,          2'b00};
      vecs[8]  = '{1'b0, 32'h0000_001C, 32'h0,         4'h0, 32'hCAFE_F00D,  2'b00};
      vecs[9]  = '{1'b1, 32'h0000_0020, 32'h5555_5555, 4'hF, 32'h0,          2'b10};
      vecs[10] = '{1'b0, 32'h0000_0020, 32'h0,         4'h0, 32'h0,          2'b10};
      vecs[11] = '{1'b0, 32'h0000_001C, 32'h0,         4'h0, 32'hCAFE_F00D,  2'b00};
      vecs[12] = '{1'b1, 32'hFFFF_FFFC, 32'h0000_0001, 4'hF, 32'h0,          2'b10};
      vecs[13] = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'h0,          2'b00};
      vecs[14] = '{1'b1, 32'h0000_000C, 32'h1111_1111, 4'hF, 32'h0,          2'b00};
      vecs[15] = '{1'b0, 32'h0000_0008, 32'h0,         4'h0, 32'h0,          2'b00};

      tick(); tick();
      a_reset = 1'b0;
      chk("rst_aw_ready", {31'b0, aw_ready}, 32'h1);
      chk("rst_w_ready",  {31'b0, w_ready},  32'h1);
      chk("rst_ar_ready", {31'b0, ar_ready}, 32'h1);
      chk("rst_valids",   {30'b0, b_valid, r_valid}, 32'h0);
      chk("rst_outputs",  r_data | {30'b0, b_resp | r_resp}, 32'h0);
      chk("rst_reg0",     reg0_out, 32'h0);
      tick();

      for (int i = 0; i < 16; i++) begin
         if (vecs[i].is_wr) begin
            axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, rs);
            chk($sformatf("vec%0d_b_resp", i), {30'b0, rs}, {30'b0, vecs[i].exp_resp});
         end else begin
            axi_read(vecs[i].addr, rd, rs);
            chk($sformatf("vec%0d_r_data", i), rd, vecs[i].exp_data);
            chk($sformatf("vec%0d_r_resp", i), {30'b0, rs}, {30'b0, vecs[i].exp_resp});
         end
      end

      // W arrives 3 cycles ahead of AW; nothing commits until AW
      w_data = 32'h1234_5678; w_strb = 4'hF; w_valid = 1'b1;
      tick();
      w_valid = 1'b0;
      chk("wfirst_w_ready", {31'b0, w_ready}, 32'h0);
      chk("wfirst_aw_ready", {31'b0, aw_ready}, 32'h1);
      for (int c = 0; c < 3; c++) begin
         chk("wfirst_no_b", {31'b0, b_valid}, 32'h0);
         chk("wfirst_no_commit", reg0_out, 32'h0);
         if (c < 2) tick();
      end
      aw_addr = 32'h0; aw_valid = 1'b1;
      tick();
      aw_valid = 1'b0;
      chk("wfirst_b_valid", {31'b0, b_valid}, 32'h1);
      chk("wfirst_b_resp", {30'b0, b_resp}, 32'h0);
      chk("wfirst_reg0_out", reg0_out, 32'h1234_5678);
      b_ready = 1'b1;
      tick();
      b_ready = 1'b0;
      chk("wfirst_back_idle", {30'b0, aw_ready, w_ready}, 32'h3);

      // Backpressure with a write and a read of reg3 on the same edge
      aw_addr = 32'hC; w_data = 32'h2222_2222; w_strb = 4'hF; aw_valid = 1'b1; w_valid = 1'b1;
      ar_addr = 32'hC; ar_valid = 1'b1;
      tick();
      aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
      for (int c = 0; c < 5; c++) begin
         chk("bp_b_valid", {31'b0, b_valid}, 32'h1);
         chk("bp_r_valid", {31'b0, r_valid}, 32'h1);
         chk("bp_r_data_prewrite", r_data, 32'h1111_1111);
         chk("bp_resps", {28'b0, b_resp, r_resp}, 32'h0);
         chk("bp_readies", {29'b0, aw_ready, w_ready, ar_ready}, 32'h0);
         tick();
      end
      b_ready = 1'b1; r_ready = 1'b1;
      tick();
      b_ready = 1'b0; r_ready = 1'b0;
      chk("bp_released", {27'b0, b_valid, r_valid, aw_ready, w_ready, ar_ready}, 32'h7);
      axi_read(32'hC, rd, rs);
      chk("bp_reg3_after", rd, 32'h2222_2222);

      // Reset while the write side sits in W_ADDR and the read side in R_RESP
      aw_addr = 32'h8; aw_valid = 1'b1; ar_addr = 32'h4; ar_valid = 1'b1;
      tick();
      aw_valid = 1'b0; ar_valid = 1'b0;
      chk("pre_rst_w_addr", {30'b0, aw_ready, w_ready}, 32'h1);
      chk("pre_rst_r_resp", {31'b0, r_valid}, 32'h1);
      a_reset = 1'b1;
      tick();
      a_reset = 1'b0;
      chk("mid_rst_valids", {30'b0, b_valid, r_valid}, 32'h0);
      chk("mid_rst_readies", {29'b0, aw_ready, w_ready, ar_ready}, 32'h7);
      chk("mid_rst_reg0", reg0_out, 32'h0);
      w_data = 32'h7777_7777; w_strb = 4'hF; w_valid = 1'b1;
      tick();
      w_valid = 1'b0;
      chk("mid_rst_no_stale_aw", {31'b0, b_valid}, 32'h0);
      aw_addr = 32'h10; aw_valid = 1'b1;
      tick();
      aw_valid = 1'b0;
      b_ready = 1'b1;
      tick();
      b_ready = 1'b0;
      axi_read(32'h4, rd, rs);
      chk("mid_rst_reg1_cleared", rd, 32'h0);
      axi_read(32'h8, rd, rs);
      chk("mid_rst_reg2_untouched", rd, 32'h0);
      axi_read(32'h10, rd, rs);
      chk("mid_rst_reg4_written", rd, 32'h7777_7777);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
